// File: rtl/fifo_block_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_block_packer_if
//
// Bundles the byte-FIFO read side and the cipher-core block side of the
// packer into one interface.
//
//   master : the packer (drives the pop request and the block handshake)
//   slave  : the environment (FIFO + cipher core)
//
// Signals (named from the packer's point of view):
//   i_fifo_data   FIFO read data, valid the cycle after o_fifo_rd_en
//   i_fifo_empty  FIFO empty flag
//   o_fifo_rd_en  FIFO pop request
//   o_block       assembled block, word 0 in the most significant slot
//   o_valid       o_block holds a complete block
//   i_ready       cipher core accepts the block
//   i_flush       (PACKER_PAD_EN only) emit the partial block zero-padded
//   o_len         (PACKER_PAD_EN only) number of real words in o_block
//
// Optional feature macro: PACKER_PAD_EN
// -----------------------------------------------------------------------------
interface fifo_block_packer_if #(
    parameter int WIDTH       = 8,
    parameter int BLOCK_BYTES = 16
);
    localparam int CNT_W = $clog2(BLOCK_BYTES + 1);

    logic [WIDTH-1:0]             i_fifo_data;
    logic                         i_fifo_empty;
    logic                         o_fifo_rd_en;
    logic [WIDTH*BLOCK_BYTES-1:0] o_block;
    logic                         o_valid;
    logic                         i_ready;

`ifdef PACKER_PAD_EN
    logic                         i_flush;
    logic [CNT_W-1:0]             o_len;

    modport master (
        input  i_fifo_data, i_fifo_empty, i_ready, i_flush,
        output o_fifo_rd_en, o_block, o_valid, o_len
    );

    modport slave (
        output i_fifo_data, i_fifo_empty, i_ready, i_flush,
        input  o_fifo_rd_en, o_block, o_valid, o_len
    );
`else
    modport master (
        input  i_fifo_data, i_fifo_empty, i_ready,
        output o_fifo_rd_en, o_block, o_valid
    );

    modport slave (
        output i_fifo_data, i_fifo_empty, i_ready,
        input  o_fifo_rd_en, o_block, o_valid
    );
`endif

endinterface : fifo_block_packer_if

// File: rtl/fifo_block_packer.sv
// -----------------------------------------------------------------------------
// fifo_block_packer
//
// Pops WIDTH-bit words from the upstream byte FIFO (one pop per clock while a
// block is filling, 1-cycle read latency) and assembles BLOCK_BYTES of them
// into one block for the cipher core. The completed block is presented on a
// valid/ready handshake and held stable until accepted.
//
// Ports:
//   i_clk   system clock, all state updates on the rising edge
//   i_rst   synchronous, active-high reset
//   bus     fifo_block_packer_if.master (FIFO read side + block handshake)
//
// Optional feature macro: PACKER_PAD_EN
//   When defined, i_flush emits a partial block with the unused slots zeroed
//   and o_len reports the number of real words. When undefined, only full
//   blocks are emitted and o_len / i_flush do not exist.
// -----------------------------------------------------------------------------
module fifo_block_packer #(
    parameter int WIDTH       = 8,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fifo_block_packer_if.master  bus
);

    localparam int CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam int BLK_W = WIDTH * BLOCK_BYTES;

    typedef enum logic {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;   // pops issued this block
    logic [CNT_W-1:0]   byte_cnt_q,   byte_cnt_d;     // words captured this block
    logic               rd_pending_q;                 // a popped word arrives this cycle
    logic [BLK_W-1:0]   block_q,      block_d;
    logic               valid_q,      valid_d;
`ifdef PACKER_PAD_EN
    logic [CNT_W-1:0]   len_q,        len_d;
`endif

    logic               rd_en;
    logic               flush_take;   // flush is emitted at this edge
    logic               flush_hold;   // flush is waiting; no new pops allowed

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        issued_cnt_d = issued_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        block_d      = block_q;
        valid_d      = valid_q;
`ifdef PACKER_PAD_EN
        len_d        = len_q;
`endif
        rd_en        = 1'b0;
        flush_take   = 1'b0;
        flush_hold   = 1'b0;

`ifdef PACKER_PAD_EN
        // A flush stops new pops as soon as there is something to emit, so a
        // word already in flight lands first and the flush follows next cycle
        // (provided i_flush is still high).
        flush_hold = bus.i_flush && (state_q == S_FILL) &&
                     (rd_pending_q || (byte_cnt_q != '0));
        flush_take = bus.i_flush && (state_q == S_FILL) &&
                     !rd_pending_q && (byte_cnt_q != '0);
`endif

        unique case (state_q)
            S_FILL: begin
                // Pop whenever data is available and the block still has
                // unrequested slots; never pops past the block boundary.
                rd_en = !bus.i_fifo_empty &&
                        (issued_cnt_q < CNT_W'(BLOCK_BYTES)) &&
                        !i_rst && !flush_hold;

                if (rd_en) begin
                    issued_cnt_d = issued_cnt_q + CNT_W'(1);
                end

                if (rd_pending_q) begin
                    // Word k goes to slot k counted from the MSB end.
                    for (int k = 0; k < BLOCK_BYTES; k++) begin
                        if (byte_cnt_q == CNT_W'(k)) begin
                            block_d[(BLOCK_BYTES-1-k)*WIDTH +: WIDTH] = bus.i_fifo_data;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);

                    if (byte_cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
                        state_d = S_OUT;
                        valid_d = 1'b1;
`ifdef PACKER_PAD_EN
                        len_d   = CNT_W'(BLOCK_BYTES);
`endif
                    end
                end else if (flush_take) begin
`ifdef PACKER_PAD_EN
                    // Zero the slots that never received a word.
                    for (int k = 0; k < BLOCK_BYTES; k++) begin
                        if (CNT_W'(k) >= byte_cnt_q) begin
                            block_d[(BLOCK_BYTES-1-k)*WIDTH +: WIDTH] = '0;
                        end
                    end
                    len_d   = byte_cnt_q;
`endif
                    state_d = S_OUT;
                    valid_d = 1'b1;
                end
            end

            S_OUT: begin
                // Block and valid hold until the core takes the block.
                if (valid_q && bus.i_ready) begin
                    valid_d      = 1'b0;
                    issued_cnt_d = '0;
                    byte_cnt_d   = '0;
                    state_d      = S_FILL;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values regardless of statement order.
        if (i_rst) begin
            // NOTE: the block register is reset too, because o_block must read
            // zero after reset rather than stale data from an earlier block.
            state_q      <= S_FILL;
            issued_cnt_q <= '0;
            byte_cnt_q   <= '0;
            rd_pending_q <= 1'b0;   // discards any word already in flight
            block_q      <= '0;
            valid_q      <= 1'b0;
`ifdef PACKER_PAD_EN
            len_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            issued_cnt_q <= issued_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rd_pending_q <= rd_en;
            block_q      <= block_d;
            valid_q      <= valid_d;
`ifdef PACKER_PAD_EN
            len_q        <= len_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.o_fifo_rd_en = rd_en;
    assign bus.o_block      = block_q;
    assign bus.o_valid      = valid_q;
`ifdef PACKER_PAD_EN
    assign bus.o_len        = len_q;
`endif

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst)
        rd_en |-> !bus.i_fifo_empty);

    a_no_over_read : assert property (@(posedge i_clk)
        issued_cnt_q <= CNT_W'(BLOCK_BYTES));

    a_hold_block : assert property (@(posedge i_clk) disable iff (i_rst)
        (valid_q && !bus.i_ready) |=> (valid_q && $stable(block_q)));

endmodule : fifo_block_packer

// File: tb/tb_fifo_block_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_block_packer
//
// Directed bench for fifo_block_packer. A small FIFO model feeds the packer
// with 1-cycle read latency. Expected blocks are queued when stimulus is
// issued; a monitor pops and compares them on every accepted handshake.
// Timing within a 10 ns cycle (posedge = p):
//   p+1  stimulus drives rst/ready/flush and loads the FIFO queue
//   p+2  FIFO model updates read data and empty flag
//   p+5  monitor and FIFO model sample DUT outputs (negedge)
//   p+6  directed checks in the main sequence
// -----------------------------------------------------------------------------
module tb_fifo_block_packer;

    localparam int WIDTH = 8;
    localparam int BB    = 16;
    localparam int BW    = WIDTH * BB;

    typedef struct {
        logic [BW-1:0] blk;
        logic [4:0]    len;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fifo_block_packer_if #(.WIDTH(WIDTH), .BLOCK_BYTES(BB)) bus ();

    fifo_block_packer #(.WIDTH(WIDTH), .BLOCK_BYTES(BB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          cyc    = 0;
    int          n_pops = 0;
    logic [7:0]  fq[$];
    exp_t        sb[$];
    int          acc_cyc[$];
    exp_t        mon_e;
    logic [7:0]  hold;
    logic        pop_prev;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #5;
    endtask

    task automatic push_run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
    endtask

    task automatic expect_blk(input logic [BW-1:0] b, input logic [4:0] l);
        exp_t e;
        e.blk = b;
        e.len = l;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string name, input int budget, output int vcyc);
        vcyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            mid();
            if (bus.o_valid) begin
                vcyc = cyc;
                return;
            end
        end
        check(name, BW'(bus.o_valid), BW'(1));
    endtask

    task automatic wait_first_pop(input int budget, output int pcyc);
        pcyc = -1;
        for (int i = 0; i < budget; i++) begin
            mid();
            if (bus.o_fifo_rd_en) begin
                pcyc = cyc;
                return;
            end
            tick();
        end
        check("first_pop_timeout", BW'(bus.o_fifo_rd_en), BW'(1));
    endtask

    // FIFO model: data appears the cycle after the pop; never pops when empty.
    initial begin
        bus.i_fifo_data  = '0;
        bus.i_fifo_empty = 1'b1;
        pop_prev         = 1'b0;
        hold             = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pop_prev) bus.i_fifo_data = hold;
            bus.i_fifo_empty = (fq.size() == 0);
            @(negedge clk);
            pop_prev = 1'b0;
            if (rst) check("rd_en_in_reset", BW'(bus.o_fifo_rd_en), BW'(0));
            if (bus.o_fifo_rd_en) begin
                check("no_underflow", BW'(bus.i_fifo_empty), BW'(0));
                n_pops++;
                if (fq.size() > 0) hold = fq.pop_front();
                pop_prev = 1'b1;
            end
        end
    end

    // Scoreboard monitor: compare on every accepted block.
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            acc_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_block", BW'(sb.size()), BW'(1));
            end else begin
                mon_e = sb.pop_front();
                check("block", bus.o_block, mon_e.blk);
`ifdef PACKER_PAD_EN
                check("len", BW'(bus.o_len), BW'(mon_e.len));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    localparam logic [BW-1:0] E1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BW-1:0] E2 = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [BW-1:0] E3 = 128'ha0a1a2a3a4a5a6a7b0b1b2b3b4b5b6b7;
    localparam logic [BW-1:0] E4 = 128'h101112131415161718191a1b1c1d1e1f;
`ifdef PACKER_PAD_EN
    localparam logic [BW-1:0] E6 = 128'hdeadbe00_00000000_00000000_00000000;
`endif

    initial begin
        int pc, vc, p0;
        rst         = 1'b1;
        bus.i_ready = 1'b0;
`ifdef PACKER_PAD_EN
        bus.i_flush = 1'b0;
`endif
        tick();
        tick();
        mid();
        check("reset_block", bus.o_block, BW'(0));
        check("reset_valid", BW'(bus.o_valid), BW'(0));
        check("reset_rd_en", BW'(bus.o_fifo_rd_en), BW'(0));
`ifdef PACKER_PAD_EN
        check("reset_len", BW'(bus.o_len), BW'(0));
`endif
        tick();
        rst = 1'b0;

        // 1: one block, ready high, first-block latency and single-cycle valid
        tick();
        bus.i_ready = 1'b1;
        p0 = n_pops;
        expect_blk(E1, 5'd16);
        push_run(8'h00, 16);
        wait_first_pop(5, pc);
        wait_valid("t1_valid_timeout", 30, vc);
        check("t1_latency", BW'(vc - pc), BW'(BB + 1));
        tick();
        mid();
        check("t1_valid_one_cycle", BW'(bus.o_valid), BW'(0));
        check("t1_pops", BW'(n_pops - p0), BW'(16));

        // 2: back-pressure for 5 cycles, next block queued in the FIFO meanwhile
        tick();
        bus.i_ready = 1'b0;
        expect_blk(E1, 5'd16);
        push_run(8'h00, 16);
        wait_valid("t2_valid_timeout", 30, vc);
        expect_blk(E2, 5'd16);
        push_run(8'h20, 16);
        check("t2_hold_rd_en", BW'(bus.o_fifo_rd_en), BW'(0));
        for (int i = 1; i < 5; i++) begin
            tick();
            mid();
            check("t2_hold_valid", BW'(bus.o_valid), BW'(1));
            check("t2_hold_block", bus.o_block, E1);
            check("t2_hold_rd_en", BW'(bus.o_fifo_rd_en), BW'(0));
        end
        tick();
        bus.i_ready = 1'b1;
        mid();
        check("t2_accept_valid", BW'(bus.o_valid), BW'(1));
        tick();
        mid();
        check("t2_valid_dropped", BW'(bus.o_valid), BW'(0));
        check("t2_pop_after_accept", BW'(bus.o_fifo_rd_en), BW'(1));
        wait_valid("t2b_valid_timeout", 30, vc);
        tick();

        // 3: FIFO runs dry mid-block for 20 cycles, then resumes
        tick();
        p0 = n_pops;
        expect_blk(E3, 5'd16);
        push_run(8'hA0, 8);
        for (int i = 0; i < 12; i++) tick();
        mid();
        check("t3_pops_first_half", BW'(n_pops - p0), BW'(8));
        for (int i = 0; i < 20; i++) begin
            tick();
            mid();
            check("t3_stall_rd_en", BW'(bus.o_fifo_rd_en), BW'(0));
            check("t3_stall_valid", BW'(bus.o_valid), BW'(0));
        end
        tick();
        push_run(8'hB0, 8);
        wait_valid("t3_valid_timeout", 30, vc);
        tick();
        check("t3_pops_total", BW'(n_pops - p0), BW'(16));

        // 4: reset after 5 captured words; next block from fresh words only
        tick();
        push_run(8'hE0, 10);
        wait_first_pop(5, pc);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        fq.delete();
        mid();
        check("t4_rd_en_in_reset", BW'(bus.o_fifo_rd_en), BW'(0));
        tick();
        rst = 1'b0;
        mid();
        check("t4_reset_block", bus.o_block, BW'(0));
        check("t4_reset_valid", BW'(bus.o_valid), BW'(0));
`ifdef PACKER_PAD_EN
        check("t4_reset_len", BW'(bus.o_len), BW'(0));
`endif
        tick();
        expect_blk(E4, 5'd16);
        push_run(8'h10, 16);
        wait_valid("t4_valid_timeout", 30, vc);
        tick();

        // 5: 32 words back to back, steady-state block period
        tick();
        p0 = n_pops;
        acc_cyc.delete();
        expect_blk(E1, 5'd16);
        expect_blk(E4, 5'd16);
        push_run(8'h00, 32);
        for (int i = 0; i < 80; i++) begin
            tick();
            mid();
            if (acc_cyc.size() >= 2) break;
        end
        check("t5_blocks", BW'(acc_cyc.size()), BW'(2));
        if (acc_cyc.size() >= 2) check("t5_period", BW'(acc_cyc[1] - acc_cyc[0]), BW'(BB + 2));
        check("t5_pops", BW'(n_pops - p0), BW'(32));

`ifdef PACKER_PAD_EN
        // 6: partial block flushed with zero padding
        tick();
        expect_blk(E6, 5'd3);
        push_run(8'hDE, 1);
        push_run(8'hAD, 1);
        push_run(8'hBE, 1);
        for (int i = 0; i < 6; i++) tick();
        bus.i_flush = 1'b1;
        wait_valid("t6_valid_timeout", 5, vc);
        tick();
        bus.i_flush = 1'b0;
        // flush with an empty block is ignored
        tick();
        bus.i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mid();
            check("t6_empty_flush_valid", BW'(bus.o_valid), BW'(0));
        end
        tick();
        bus.i_flush = 1'b0;
`endif

        for (int i = 0; i < 4; i++) tick();
        check("scoreboard_drained", BW'(sb.size()), BW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_block_packer
